// File: rtl/core_seq.sv
// Instruction sequencer for core: one start pulse runs every kernel position
// (weight/activation fetch, load, execute, OFIFO drain) and then the psum accumulation.
module core_seq #(
  parameter int unsigned row    = 8,
  parameter int unsigned col    = 8,
  parameter int unsigned in_w   = 6,
  parameter int unsigned k_w    = 3,
  parameter int unsigned addr_w = 11,
  parameter int unsigned w_base = 1024,
  parameter int unsigned p_base = 0,
  parameter int unsigned drain  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [34:0]       inst,
  output logic              sfp_clr,
  output logic              out_valid,
  output logic [addr_w-1:0] onij,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LenNij  = in_w * in_w;
  localparam int unsigned LenKij  = k_w * k_w;
  localparam int unsigned OutW    = in_w - k_w + 1;
  localparam int unsigned LenOnij = OutW * OutW;

  typedef logic [addr_w-1:0] addr_t;

  localparam addr_t ColA     = addr_t'(col);
  localparam addr_t InWA     = addr_t'(in_w);
  localparam addr_t KwA      = addr_t'(k_w);
  localparam addr_t OutWA    = addr_t'(OutW);
  localparam addr_t LenNijA  = addr_t'(LenNij);
  localparam addr_t LenKijA  = addr_t'(LenKij);
  localparam addr_t LenOnijA = addr_t'(LenOnij);
  localparam addr_t DrainA   = addr_t'(drain);
  localparam addr_t WBaseA   = addr_t'(w_base);
  localparam addr_t PBaseA   = addr_t'(p_base);

  // CEN/WEN of both memories high, everything else low.
  localparam logic [34:0] InstIdle = 35'h1_800C_0000;

  typedef enum logic [3:0] {
    StIdle, StWl0, StWload, StDrain, StXl0, StExec, StOfifo, StAcc, StDone
  } state_e;

  // The row count only shapes the attached PE array, not the sequence.
  logic unused_row;
  assign unused_row = ^row;

  state_e state_q, state_d;
  addr_t  cnt_q, cnt_d, kij_q, kij_d;
  addr_t  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  addr_t  o_q, o_d, ox_q, ox_d, oy_q, oy_d, jx_q, jx_d, jy_q, jy_d;
  logic   rd_d, wr_d;

  logic [34:0] inst_q, inst_d;
  logic        sfp_clr_q, sfp_clr_d, out_valid_q, out_valid_d;
  logic        busy_q, busy_d, done_q, done_d;
  addr_t       onij_q, onij_d;
  addr_t       xa, pa;

  // Next-state logic: *_q describe the cycle currently shown on inst.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    kij_d    = kij_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    o_d      = o_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    jx_d     = jx_q;
    jy_d     = jy_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWl0;
          cnt_d   = '0;
          kij_d   = '0;
        end
      end
      StWl0: begin
        if (cnt_q == ColA) begin
          state_d = StWload;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWload: begin
        if (cnt_q == ColA - 1'b1) begin
          state_d = (drain == 0) ? StXl0 : StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == DrainA - 1'b1) begin
          state_d = StXl0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StXl0: begin
        if (cnt_q == LenNijA) begin
          state_d = StExec;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StExec: begin
        if (cnt_q == LenNijA - 1'b1) begin
          state_d  = StOfifo;
          rd_d     = ofifo_valid;
          rd_cnt_d = {{(addr_w-1){1'b0}}, ofifo_valid};
          wr_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StOfifo: begin
        if (wr_cnt_q == LenNijA) begin
          cnt_d = '0;
          if (kij_q == LenKijA - 1'b1) begin
            state_d = StAcc;
            o_d     = '0;
            ox_d    = '0;
            oy_d    = '0;
            jx_d    = '0;
            jy_d    = '0;
          end else begin
            state_d = StWl0;
            kij_d   = kij_q + 1'b1;
          end
        end else begin
          rd_d     = ofifo_valid && (rd_cnt_q < LenNijA);
          rd_cnt_d = rd_cnt_q + rd_d;
          // Each word read last cycle is written to psum SRAM this cycle.
          wr_d     = inst_q[6];
          wr_cnt_d = wr_cnt_q + wr_d;
        end
      end
      StAcc: begin
        if (cnt_q == LenKijA + 2'd2) begin
          if (o_q == LenOnijA - 1'b1) begin
            state_d = StDone;
          end else begin
            o_d   = o_q + 1'b1;
            cnt_d = '0;
            jx_d  = '0;
            jy_d  = '0;
            if (ox_q == OutWA - 1'b1) begin
              ox_d = '0;
              oy_d = oy_q + 1'b1;
            end else begin
              ox_d = ox_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Step the kernel offset between consecutive psum reads only.
          if (cnt_q != '0 && cnt_q < LenKijA) begin
            if (jx_q == KwA - 1'b1) begin
              jx_d = '0;
              jy_d = jy_q + 1'b1;
            end else begin
              jx_d = jx_q + 1'b1;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so that inst is a clean register.
  always_comb begin
    inst_d      = InstIdle;
    sfp_clr_d   = 1'b0;
    out_valid_d = 1'b0;
    onij_d      = onij_q;
    done_d      = 1'b0;
    busy_d      = (state_d != StIdle) && (state_d != StDone);
    xa          = '0;
    pa          = '0;
    unique case (state_d)
      StWl0: begin
        xa = WBaseA + kij_d * ColA + cnt_d;
        if (cnt_d < ColA) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = 11'(xa);
        end
        if (cnt_d != '0) inst_d[2] = 1'b1;
      end
      StWload: begin
        inst_d[3] = 1'b1;
        inst_d[0] = 1'b1;
      end
      StXl0: begin
        xa = cnt_d;
        if (cnt_d < LenNijA) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = 11'(xa);
        end
        if (cnt_d != '0) inst_d[2] = 1'b1;
      end
      StExec: begin
        inst_d[3] = 1'b1;
        inst_d[1] = 1'b1;
      end
      StOfifo: begin
        inst_d[6] = rd_d;
        pa = PBaseA + kij_d * LenNijA + wr_cnt_q;
        if (wr_d) begin
          inst_d[32]    = 1'b0;
          inst_d[31]    = 1'b0;
          inst_d[30:20] = 11'(pa);
        end
      end
      StAcc: begin
        pa = PBaseA + (cnt_d - 1'b1) * LenNijA + (oy_d + jy_d) * InWA + ox_d + jx_d;
        if (cnt_d == '0) sfp_clr_d = 1'b1;
        if (cnt_d != '0 && cnt_d <= LenKijA) begin
          inst_d[32]    = 1'b0;
          inst_d[30:20] = 11'(pa);
        end
        if (cnt_d >= 2'd2 && cnt_d <= LenKijA + 1'b1) inst_d[34:33] = 2'b11;
        if (cnt_d == LenKijA + 2'd2) begin
          out_valid_d = 1'b1;
          onij_d      = o_d;
        end
      end
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      kij_q       <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      o_q         <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      jx_q        <= '0;
      jy_q        <= '0;
      inst_q      <= InstIdle;
      sfp_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      onij_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kij_q       <= kij_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      o_q         <= o_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      jx_q        <= jx_d;
      jy_q        <= jy_d;
      inst_q      <= inst_d;
      sfp_clr_q   <= sfp_clr_d;
      out_valid_q <= out_valid_d;
      onij_q      <= onij_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign inst      = inst_q;
  assign sfp_clr   = sfp_clr_q;
  assign out_valid = out_valid_q;
  assign onij      = onij_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: default-parameter runs (nominal, OFIFO stall, abort/restart)
// and a small-array instance for the parameter sweep.
module tb_core_seq;

  localparam logic [34:0] Idle = 35'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b1;
  logic [34:0] inst;
  logic        sfp_clr, out_valid, busy, done;
  logic [10:0] onij;

  logic        start2 = 1'b0;
  logic [34:0] inst2;
  logic        sfp_clr2, out_valid2, busy2, done2;
  logic [10:0] onij2;

  always #5 clk = ~clk;

  core_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .sfp_clr     (sfp_clr),
    .out_valid   (out_valid),
    .onij        (onij),
    .busy        (busy),
    .done        (done)
  );

  core_seq #(.row(4), .col(4), .in_w(5), .k_w(2)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .start       (start2),
    .ofifo_valid (1'b1),
    .inst        (inst2),
    .sfp_clr     (sfp_clr2),
    .out_valid   (out_valid2),
    .onij        (onij2),
    .busy        (busy2),
    .done        (done2)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Per-cycle trace of one run of dut; index t = 0 is the first cycle with busy high.
  logic [34:0] tr_inst[$];
  logic        tr_busy[$], tr_clr[$], tr_ov[$];
  logic [10:0] tr_onij[$];
  int          done_t;

  function automatic int cnt_bit(int a, int b, int k);
    int n = 0;
    for (int t = a; t <= b && t < tr_inst.size(); t++) if (tr_inst[t][k]) n++;
    return n;
  endfunction

  function automatic int cnt_wr(int a, int b);
    int n = 0;
    for (int t = a; t <= b && t < tr_inst.size(); t++)
      if (!tr_inst[t][32] && !tr_inst[t][31]) n++;
    return n;
  endfunction

  task automatic run1(input int budget, input bit stall);
    int rd_seen = 0;
    int gap = 0;
    tr_inst.delete(); tr_busy.delete(); tr_clr.delete(); tr_ov.delete(); tr_onij.delete();
    done_t = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    for (int t = 0; t < budget; t++) begin
      if (t > 0) @(negedge clk);
      start = 1'b0;
      tr_inst.push_back(inst); tr_busy.push_back(busy); tr_clr.push_back(sfp_clr);
      tr_ov.push_back(out_valid); tr_onij.push_back(onij);
      if (t == 50) start = 1'b1;  // must be ignored mid-run
      if (stall) begin
        if (gap > 0) begin
          gap--;
          if (gap == 0) ofifo_valid = 1'b1;
        end else if (inst[6]) begin
          rd_seen++;
          if (rd_seen == 10) begin
            ofifo_valid = 1'b0;
            gap = 5;
          end
        end
      end
      if (done) begin
        done_t = t;
        break;
      end
    end
    if (done_t < 0) check("run_timeout", 0, 1);
    else begin
      start = 1'b1;  // pulse during the DONE cycle is ignored
      @(negedge clk); start = 1'b0;
      check("start_in_done_busy", busy, 0);
      check("start_in_done_inst", inst, Idle);
    end
  endtask

  // Checks shared by every unstalled default-parameter run.
  task automatic analyze_nominal(input string p);
    int wq[$], pr[$], ovt[$];
    int bad;
    logic [10:0] ovn[$];
    check({p, "_t0_busy"}, tr_busy[0], 1);
    check({p, "_t0_axmem"}, tr_inst[0][17:7], 1024);
    check({p, "_t0_cen_wen_x"}, tr_inst[0][19:18], 2'b01);
    bad = 0;
    for (int t = 0; t < 8; t++)
      if (tr_inst[t][19] !== 1'b0 || tr_inst[t][17:7] !== 11'(1024 + t)) bad++;
    check({p, "_wl0_addr_bad"}, bad, 0);
    check({p, "_wl0_last_addr"}, tr_inst[7][17:7], 1031);
    check({p, "_l0wr_t0"}, tr_inst[0][2], 0);
    check({p, "_l0wr_t1_8"}, cnt_bit(1, 8, 2), 8);
    check({p, "_load_k0"}, cnt_bit(0, 136, 0), 8);
    check({p, "_load_win"}, cnt_bit(9, 16, 0), 8);
    bad = 0;
    for (int t = 17; t <= 26; t++) if (tr_inst[t] !== Idle) bad++;
    check({p, "_drain_idle_bad"}, bad, 0);
    check({p, "_xl0_l0wr"}, cnt_bit(28, 63, 2), 36);
    check({p, "_exec_k0"}, cnt_bit(0, 136, 1), 36);
    check({p, "_exec_win"}, cnt_bit(64, 99, 1), 36);
    check({p, "_load_total"}, cnt_bit(0, tr_inst.size() - 1, 0), 72);
    for (int t = 0; t < tr_inst.size(); t++) begin
      if (!tr_inst[t][32] && !tr_inst[t][31]) wq.push_back(int'(tr_inst[t][30:20]));
      if (!tr_inst[t][32] && tr_inst[t][31]) pr.push_back(int'(tr_inst[t][30:20]));
      if (tr_ov[t]) begin ovt.push_back(t); ovn.push_back(tr_onij[t]); end
    end
    check({p, "_wr_count"}, wq.size(), 324);
    bad = 0;
    foreach (wq[i]) if (wq[i] != i) bad++;
    check({p, "_wr_contig_bad"}, bad, 0);
    if (wq.size() == 324) begin
      check({p, "_wr_k8_first"}, wq[288], 288);
      check({p, "_wr_k8_last"}, wq[323], 323);
    end
    check({p, "_k0_wr_101_136"}, cnt_wr(101, 136), 36);
    check({p, "_acc_rd_count"}, pr.size(), 144);
    if (pr.size() == 144) begin
      check({p, "_acc_o0_j0"}, pr[0], 0);
      check({p, "_acc_o5_j4"}, pr[49], 158);
      check({p, "_acc_o15_j8"}, pr[143], 323);
    end
    check({p, "_acc_bits"}, cnt_bit(0, tr_inst.size() - 1, 34), 144);
    bad = 0;
    foreach (tr_inst[t]) if (tr_inst[t][34] !== tr_inst[t][33]) bad++;
    check({p, "_acc_equal"}, bad, 0);
    check({p, "_ov_count"}, ovt.size(), 16);
    bad = 0;
    foreach (ovt[i]) begin
      if (ovn[i] !== 11'(i)) bad++;
      if (ovt[i] < 11 || tr_clr[ovt[i] - 11] !== 1'b1) bad++;
    end
    check({p, "_ov_onij_clr_bad"}, bad, 0);
    bad = 0;
    foreach (tr_clr[t]) if (tr_clr[t]) bad++;
    check({p, "_clr_count"}, bad, 16);
    check({p, "_done_t"}, done_t, 1425);
    if (done_t >= 0) check({p, "_busy_at_done"}, tr_busy[done_t], 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t10, d2, n_load, n_exec, n_ov, last_pr, last_on, exec_n, bad;
    bit seen_k3, abort_ok;

    // Held in reset with start toggling: outputs stay idle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = (i % 2 == 0);
      check("rst_inst", inst, Idle);
      check("rst_busy", busy, 0);
    end
    check("rst_outs", {sfp_clr, out_valid, done, onij}, 0);
    @(negedge clk); start = 1'b0; reset = 1'b1;
    @(negedge clk);

    run1(3000, 1'b0);
    analyze_nominal("nom");

    // OFIFO stall after the 10th read of kij 0.
    run1(3000, 1'b1);
    t10 = -1;
    bad = 0;
    foreach (tr_inst[t]) if (tr_inst[t][6]) begin
      bad++;
      if (bad == 10 && t10 < 0) t10 = t;
    end
    check("stall_t10", t10, 109);
    check("stall_gap_rd", cnt_bit(t10 + 1, t10 + 5, 6), 0);
    check("stall_gap_wr", cnt_wr(t10 + 2, t10 + 5), 0);
    check("stall_k0_writes", cnt_wr(0, 141), 36);
    check("stall_k1_start", {tr_inst[142][19], tr_inst[142][17:7]}, {1'b0, 11'd1048 - 11'd16});
    bad = 0;
    last_pr = 0;
    foreach (tr_inst[t]) if (!tr_inst[t][32] && !tr_inst[t][31]) begin
      if (int'(tr_inst[t][30:20]) != last_pr) bad++;
      last_pr++;
    end
    check("stall_wr_contig_bad", bad, 0);
    check("stall_wr_total", last_pr, 324);
    check("stall_done_t", done_t, 1430);

    // Abort during EXEC of kij 3, then restart from kij 0.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen_k3 = 1'b0; abort_ok = 1'b0; exec_n = 0;
    for (int t = 0; t < 2000; t++) begin
      if (!inst[19] && inst[17:7] == 11'd1048) seen_k3 = 1'b1;
      if (seen_k3 && inst[1]) begin
        exec_n++;
        if (exec_n == 10) begin abort_ok = 1'b1; break; end
      end
      @(negedge clk);
    end
    check("abort_reached", abort_ok, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_inst_idle", inst, Idle);
    check("abort_busy", busy, 0);
    @(negedge clk); reset = 1'b1;
    run1(3000, 1'b0);
    analyze_nominal("rst");

    // Sweep instance: col 4, in_w 5, k_w 2 -> 96 cycles per kij, 7 per output pixel.
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    d2 = -1; n_load = 0; n_exec = 0; n_ov = 0; last_pr = -1; last_on = -1;
    for (int t = 0; t < 1500; t++) begin
      if (inst2[0]) n_load++;
      if (inst2[1]) n_exec++;
      if (!inst2[32] && inst2[31]) last_pr = int'(inst2[30:20]);
      if (out_valid2) begin n_ov++; last_on = int'(onij2); end
      if (done2) begin d2 = t; break; end
      @(negedge clk);
    end
    check("sw_done_t", d2, 496);
    check("sw_busy_at_done", busy2, 0);
    check("sw_load_total", n_load, 16);
    check("sw_exec_total", n_exec, 100);
    check("sw_ov_count", n_ov, 16);
    check("sw_last_onij", last_on, 15);
    check("sw_last_acc_addr", last_pr, 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/core_seq.md
# core_seq

Parametrised instruction sequencer that drives the 35-bit `inst` bus of `core` from a single `start` pulse. Per kernel position it runs the weight fetch to L0, kernel load, activation fetch to L0, execute, and OFIFO drain into psum SRAM. It then generates the psum-accumulation address stream for every output pixel. It sits between the host or top level and `core`, replacing hand-sequenced stimulus, and generalises over array size, input/kernel width and memory bases.

## Interface
- `row`, 8: PE rows.
- `col`, 8: PE columns; also the number of weight words per kij.
- `in_w`, 6: input feature-map width (square). `len_nij = in_w*in_w`.
- `k_w`, 3: kernel width. `len_kij = k_w*k_w`, `out_w = in_w-k_w+1`, `len_onij = out_w*out_w`.
- `addr_w`, 11: SRAM address width.
- `w_base`, 1024: xmem base of weights; kij word t sits at `w_base + kij*col + t`.
- `p_base`, 0: pmem base; psum (kij,nij) sits at `p_base + kij*len_nij + nij`.
- `drain`, 10: idle cycles after kernel load.
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that begins a full run. Ignored while `busy`.
- `ofifo_valid`, in, 1: from `core`.
- `inst`, out, 35: registered instruction bus. Fields:
  - [34:33] acc (both bits equal)
  - [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- `sfp_clr`, out, 1: one-cycle pulse that clears the SFP accumulator before each output pixel.
- `out_valid`, out, 1: one-cycle pulse when `sfp_out` holds a finished output pixel.
- `onij`, out, addr_w: index of the pixel flagged by `out_valid`.
- `busy`, out, 1: high from the cycle after an accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse at the end of a run.

## Operation
- Idle `inst` value: CEN_* = 1, WEN_* = 1, all other bits 0. Every state outputs this value unless it drives a field explicitly.
- FSM states: IDLE → WL0 → WLOAD → DRAIN → XL0 → EXEC → OFIFO → (next kij ? WL0 : ACC) → DONE → IDLE.
- WL0 (col+1 cycles):
  - Cycles 0..col-1: xmem read (CEN=0, WEN=1), A_xmem = w_base + kij*col + t.
  - Cycles 1..col: l0_wr = 1, because xmem read latency is 1.
- WLOAD (col cycles): l0_rd = 1, load = 1.
- DRAIN (`drain` cycles): idle value.
- XL0 (len_nij+1 cycles): xmem reads of A = 0..len_nij-1, with l0_wr delayed one cycle, same rule as WL0.
- EXEC (len_nij cycles): l0_rd = 1, execute = 1.
- OFIFO:
  - ofifo_rd = ofifo_valid, while fewer than len_nij reads have been issued.
  - One cycle after each read: pmem write (CEN=0, WEN=0), A_pmem = p_base + kij*len_nij + n, where n counts writes from 0.
  - Exit once the len_nij-th write is issued.
- ACC: for each o = 0..len_onij-1, with oy = o/out_w and ox = o%out_w:
  - Cycle 0: sfp_clr = 1.
  - Cycles 1..len_kij: pmem read (CEN=0, WEN=1), A_pmem = p_base + j*len_nij + (oy+j/k_w)*in_w + (ox+j%k_w), for j = 0..len_kij-1.
  - Cycles 2..len_kij+1: acc = 1.
  - Cycle len_kij+2: out_valid = 1, onij = o.
  - Each output pixel therefore takes len_kij+3 cycles.
- Address arithmetic: unsigned, truncated to addr_w. Exceeding the range is a parameter error; no runtime check is made.
- DONE: `done` = 1 for one cycle; `busy` drops in the same cycle.

## Timing
- Reset (`reset` = 0) is asynchronous. On reset:
  - `inst` = idle value; `sfp_clr`, `out_valid`, `done`, `busy` = 0; `onij` = 0.
  - FSM → IDLE; all counters cleared.
- Reset asserted mid-run aborts the run immediately. No partial writes are issued after deassertion.
- `start` sampled high in IDLE → first WL0 fields appear on `inst` at the next edge, and `busy` rises at that same edge.
- Stall: in OFIFO, ofifo_valid low → no read and no counter advance. Other states never stall.
- Read and write can coincide in one OFIFO cycle: ofifo_rd for word n+1 and the pmem write for word n. Both are issued.
- Cycles per kij without stall: (col+1) + col + drain + (len_nij+1) + len_nij + (len_nij+1). Defaults: 9 + 8 + 10 + 37 + 36 + 37 = 137.
- `start` pulsed during a run, or during the DONE cycle, is ignored.

## Test plan
- Reset check: hold `reset` = 0, toggle `start` → `inst` = idle value (bits 32, 31, 19, 18 set, all others 0), `busy` = 0. Release reset, pulse `start` → `busy` = 1 on the next edge, and `inst` shows A_xmem = 1024, CEN_xmem = 0, WEN_xmem = 1.
- Default parameters, ofifo_valid tied 1, kij 0:
  - A_xmem 1024..1031 followed by l0_wr.
  - load high for exactly 8 cycles, then 10 idle cycles.
  - execute high for exactly 36 cycles.
  - pmem writes at addresses 0..35.
  - kij 8 writes at 288..323.
- ACC addressing:
  - onij 0, j 0 → A_pmem 0.
  - onij 5, j 4 → 158.
  - onij 15, j 8 → 323.
  - 16 `out_valid` pulses with onij 0..15, each preceded by `sfp_clr` len_kij+2 cycles earlier.
- OFIFO stall: drop ofifo_valid for 5 cycles after the 10th read → no ofifo_rd and no pmem write during the gap. Write addresses stay contiguous and the total is still 36.
- Mid-run abort: assert reset during EXEC of kij 3 → `inst` is idle asynchronously. A fresh `start` restarts at kij 0 with A_xmem 1024.
- Parameter sweep: row = col = 4, in_w = 5, k_w = 2 → 16 load cycles total, len_onij 16, final `done` pulse, and a total cycle count that matches the formula.
